// File: rtl/image_pkg.sv
// Shared definitions for the image stream checker: FSM encoding and
// default frame geometry / counter width.
package image_pkg;

   typedef enum logic [1:0] {
      WAIT_SOF  = 2'd0,
      ACTIVE    = 2'd1,
      LAST_LINE = 2'd2
   } state_t;

   localparam int DEF_WIDTH        = 300;
   localparam int DEF_HEIGHT       = 300;
   localparam int DEF_DIM_BITWIDTH = 13;

endpackage

// File: rtl/image_stream_checker_sticky_flag.sv
// Sticky error flag: set has priority over clear so an error arriving in the
// same cycle as err_clr is never lost.
module sticky_flag (
   input  logic clk,
   input  logic rst,
   input  logic i_set,
   input  logic i_clr,
   output logic o_flag
);

   logic r_flag;

   always_ff @(posedge clk) begin
      if (rst)        r_flag <= 1'b0;
      else if (i_set) r_flag <= 1'b1;
      else if (i_clr) r_flag <= 1'b0;
   end

   assign o_flag = r_flag;

endmodule

// File: rtl/image_stream_checker.sv
// Sink for the pattern generator stream: measures frame geometry, checks the
// framing markers and the constant pixel value, and keeps sticky error flags.
module image_stream_checker
   import image_pkg::*;
#(
   parameter int                        PIXEL_BITWIDTH = 8,
   parameter int                        PIXEL_NUM      = 1,
   parameter int                        EXP_WIDTH      = DEF_WIDTH,
   parameter int                        EXP_HEIGHT     = DEF_HEIGHT,
   parameter logic [PIXEL_BITWIDTH-1:0] EXP_DATA       = 'hAA,
   parameter int                        DIM_BITWIDTH   = DEF_DIM_BITWIDTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                err_clr,
   output logic                                s_axis_ready,
   input  logic                                s_axis_valid,
   input  logic [PIXEL_BITWIDTH*PIXEL_NUM-1:0] s_axis_data,
   input  logic                                s_axis_sof,
   input  logic                                s_axis_eof,
   input  logic                                s_axis_eol,
   output logic                                frame_done,
   output logic [DIM_BITWIDTH-1:0]             meas_width,
   output logic [DIM_BITWIDTH-1:0]             meas_height,
   output logic [15:0]                         frame_cnt,
   output logic                                err_no_sof,
   output logic                                err_sof,
   output logic                                err_width,
   output logic                                err_height,
   output logic                                err_data,
   output state_t                              o_dbg_state
);

   localparam logic [DIM_BITWIDTH:0] C_PIX_STEP = (DIM_BITWIDTH+1)'(PIXEL_NUM);
   localparam logic [DIM_BITWIDTH:0] C_ONE      = (DIM_BITWIDTH+1)'(1);

   state_t                  r_state, w_state_nxt;
   logic                    r_ready;
   logic [DIM_BITWIDTH-1:0] r_pix_cnt, r_line_cnt;
   logic                    r_frame_done;
   logic [DIM_BITWIDTH-1:0] r_meas_width, r_meas_height;
   logic [15:0]             r_frame_cnt;

   logic                    w_beat, w_take, w_last, w_frame_end, w_data_bad;
   logic [DIM_BITWIDTH-1:0] w_pix_base, w_line_base, w_line_len, w_line_inc;
   logic [DIM_BITWIDTH:0]   w_pix_sum, w_line_sum;
   logic                    w_set_no_sof, w_set_sof, w_set_width, w_set_height, w_set_data;

   // A sof beat always starts a fresh frame, so its counters begin from zero.
   always_comb begin
      w_beat      = s_axis_valid & r_ready;
      w_take      = w_beat & ((r_state != WAIT_SOF) | s_axis_sof);
      w_pix_base  = s_axis_sof ? '0 : r_pix_cnt;
      w_line_base = s_axis_sof ? '0 : r_line_cnt;
      w_pix_sum   = {1'b0, w_pix_base} + C_PIX_STEP;
      w_line_sum  = {1'b0, w_line_base} + C_ONE;
      w_line_len  = w_pix_sum[DIM_BITWIDTH]  ? '1 : w_pix_sum[DIM_BITWIDTH-1:0];
      w_line_inc  = w_line_sum[DIM_BITWIDTH] ? '1 : w_line_sum[DIM_BITWIDTH-1:0];
      w_last      = s_axis_eof | ((r_state == LAST_LINE) & ~s_axis_sof);
      w_frame_end = w_take & s_axis_eol & w_last;
      w_data_bad  = 1'b0;
      for (int i = 0; i < PIXEL_NUM; i++) begin
         if (s_axis_data[i*PIXEL_BITWIDTH +: PIXEL_BITWIDTH] != EXP_DATA) w_data_bad = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_take) begin
         if (w_frame_end) w_state_nxt = WAIT_SOF;
         else if (w_last) w_state_nxt = LAST_LINE;
         else             w_state_nxt = ACTIVE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= WAIT_SOF;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready       <= 1'b0;
         r_pix_cnt     <= '0;
         r_line_cnt    <= '0;
         r_frame_done  <= 1'b0;
         r_meas_width  <= '0;
         r_meas_height <= '0;
         r_frame_cnt   <= '0;
      end else begin
         r_ready      <= 1'b1;
         r_frame_done <= w_frame_end;
         if (w_take) begin
            if (s_axis_eol) begin
               r_pix_cnt  <= '0;
               r_line_cnt <= w_line_inc;
            end else begin
               r_pix_cnt  <= w_line_len;
               r_line_cnt <= w_line_base;
            end
         end
         if (w_frame_end) begin
            r_meas_width  <= w_line_len;
            r_meas_height <= w_line_inc;
            r_frame_cnt   <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign w_set_no_sof = w_beat & ~s_axis_sof & (r_state == WAIT_SOF);
   assign w_set_sof    = w_beat & s_axis_sof & (r_state != WAIT_SOF);
   assign w_set_width  = w_take & s_axis_eol & (32'(w_line_len) != 32'(EXP_WIDTH));
   assign w_set_height = w_frame_end & (32'(w_line_inc) != 32'(EXP_HEIGHT));
   assign w_set_data   = w_take & w_data_bad;

   sticky_flag u_err_no_sof (.clk(clk), .rst(rst), .i_set(w_set_no_sof), .i_clr(err_clr), .o_flag(err_no_sof));
   sticky_flag u_err_sof    (.clk(clk), .rst(rst), .i_set(w_set_sof),    .i_clr(err_clr), .o_flag(err_sof));
   sticky_flag u_err_width  (.clk(clk), .rst(rst), .i_set(w_set_width),  .i_clr(err_clr), .o_flag(err_width));
   sticky_flag u_err_height (.clk(clk), .rst(rst), .i_set(w_set_height), .i_clr(err_clr), .o_flag(err_height));
   sticky_flag u_err_data   (.clk(clk), .rst(rst), .i_set(w_set_data),   .i_clr(err_clr), .o_flag(err_data));

   assign s_axis_ready = r_ready;
   assign frame_done   = r_frame_done;
   assign meas_width   = r_meas_width;
   assign meas_height  = r_meas_height;
   assign frame_cnt    = r_frame_cnt;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_image_stream_checker.sv
// Directed bench for image_stream_checker with a frame-level reference model
// checked every cycle, plus literal geometry/flag expectations.
module tb_image_stream_checker;
   import image_pkg::*;

   localparam int        PB  = 8;
   localparam int        PN  = 1;
   localparam int        W   = 6;
   localparam int        H   = 4;
   localparam int        DIM = 13;
   localparam logic [7:0] GOOD = 8'hAA;
   localparam logic [7:0] BAD  = 8'h55;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst = 1'b1, err_clr = 1'b0;
   logic            s_axis_valid = 1'b0, s_axis_sof = 1'b0, s_axis_eof = 1'b0, s_axis_eol = 1'b0;
   logic [PB*PN-1:0] s_axis_data = GOOD;
   logic            s_axis_ready, frame_done;
   logic [DIM-1:0]  meas_width, meas_height;
   logic [15:0]     frame_cnt;
   logic            err_no_sof, err_sof, err_width, err_height, err_data;
   state_t          dbg_state;

   image_stream_checker #(
      .PIXEL_BITWIDTH(PB), .PIXEL_NUM(PN), .EXP_WIDTH(W), .EXP_HEIGHT(H),
      .EXP_DATA(GOOD), .DIM_BITWIDTH(DIM)
   ) dut (
      .clk(clk), .rst(rst), .err_clr(err_clr), .s_axis_ready(s_axis_ready),
      .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_sof(s_axis_sof),
      .s_axis_eof(s_axis_eof), .s_axis_eol(s_axis_eol), .frame_done(frame_done),
      .meas_width(meas_width), .meas_height(meas_height), .frame_cnt(frame_cnt),
      .err_no_sof(err_no_sof), .err_sof(err_sof), .err_width(err_width),
      .err_height(err_height), .err_data(err_data), .o_dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame-level bookkeeping, values seen after each edge.
   bit m_ready = 0, m_in_frame = 0, m_last_line = 0;
   int m_pix = 0, m_lines = 0;
   bit e_done = 0, e_no_sof = 0, e_sof = 0, e_width = 0, e_height = 0, e_data = 0;
   int e_w = 0, e_h = 0, e_cnt = 0;

   task automatic model_step();
      bit beat;
      e_done = 0;
      if (rst) begin
         m_ready = 0; m_in_frame = 0; m_last_line = 0; m_pix = 0; m_lines = 0;
         {e_no_sof, e_sof, e_width, e_height, e_data} = '0;
         e_w = 0; e_h = 0; e_cnt = 0;
         return;
      end
      beat = s_axis_valid && m_ready;
      m_ready = 1;
      if (err_clr) {e_no_sof, e_sof, e_width, e_height, e_data} = '0;
      if (!beat) return;
      if (s_axis_sof) begin
         if (m_in_frame) e_sof = 1;
         m_in_frame = 1; m_last_line = 0; m_pix = 0; m_lines = 0;
      end else if (!m_in_frame) begin
         e_no_sof = 1;
         return;
      end
      if (s_axis_data != GOOD) e_data = 1;
      if (s_axis_eof) m_last_line = 1;
      m_pix += PN;
      if (s_axis_eol) begin
         if (m_pix != W) e_width = 1;
         if (m_last_line) begin
            e_w = m_pix; e_h = m_lines + 1;
            if (e_h != H) e_height = 1;
            e_cnt = (e_cnt + 1) % 65536;
            e_done = 1;
            m_in_frame = 0; m_last_line = 0; m_lines = 0;
         end else begin
            m_lines++;
         end
         m_pix = 0;
      end
   endtask

   always @(negedge clk) begin
      chk("ready", 32'(s_axis_ready), 32'(m_ready));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("meas_width", 32'(meas_width), 32'(e_w));
      chk("meas_height", 32'(meas_height), 32'(e_h));
      chk("frame_cnt", 32'(frame_cnt), 32'(e_cnt));
      chk("err_no_sof", 32'(err_no_sof), 32'(e_no_sof));
      chk("err_sof", 32'(err_sof), 32'(e_sof));
      chk("err_width", 32'(err_width), 32'(e_width));
      chk("err_height", 32'(err_height), 32'(e_height));
      chk("err_data", 32'(err_data), 32'(e_data));
      chk("state", 32'(dbg_state), !m_in_frame ? 32'd0 : (m_last_line ? 32'd2 : 32'd1));
      if (frame_done === 1'b1) n_done++;
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Idle cycles carry garbage markers that must be ignored.
   task automatic idle();
      s_axis_valid = 0; s_axis_data = 8'h00;
      s_axis_sof = 1; s_axis_eof = 1; s_axis_eol = 1;
      tick();
      s_axis_sof = 0; s_axis_eof = 0; s_axis_eol = 0; s_axis_data = GOOD;
   endtask

   task automatic send_line(input int len, input bit first, input bit last, input int bad_pix);
      for (int p = 0; p < len; p++) begin
         s_axis_valid = 1;
         s_axis_data  = (p == bad_pix) ? BAD : GOOD;
         s_axis_sof   = first && (p == 0);
         s_axis_eof   = last && (p == 0);
         s_axis_eol   = (p == len - 1);
         tick();
      end
      idle();
   endtask

   task automatic send_frame(input int width, input int height, input int bad_line,
                             input int bad_pix, input int short_line);
      for (int l = 0; l < height; l++)
         send_line((l == short_line) ? width - 1 : width, l == 0, l == height - 1,
                   (l == bad_line) ? bad_pix : -1);
   endtask

   task automatic pulse_clr();
      err_clr = 1; tick(); err_clr = 0;
   endtask

   initial begin
      int cnt0, done0;
      tick(); tick();
      chk("reset_ready", 32'(s_axis_ready), 32'd0);
      chk("reset_state", 32'(dbg_state), 32'd0);
      rst = 0;
      tick();
      chk("ready_after_reset", 32'(s_axis_ready), 32'd1);

      // nominal frames
      send_frame(W, H, -1, -1, -1);
      send_frame(W, H, -1, -1, -1);
      chk("t1_done_pulses", 32'(n_done), 32'd2);
      chk("t1_width", 32'(meas_width), 32'd6);
      chk("t1_height", 32'(meas_height), 32'd4);
      chk("t1_cnt", 32'(frame_cnt), 32'd2);
      chk("t1_flags", 32'({err_no_sof, err_sof, err_width, err_height, err_data}), 32'd0);

      // corrupt pixel, sticky until err_clr
      send_frame(W, H, 2, 3, -1);
      idle(); idle();
      chk("t2_err_data", 32'(err_data), 32'd1);
      chk("t2_others", 32'({err_no_sof, err_sof, err_width, err_height}), 32'd0);
      pulse_clr();
      chk("t2_cleared", 32'(err_data), 32'd0);

      // short line
      send_frame(W, H, -1, -1, 1);
      chk("t3_err_width", 32'(err_width), 32'd1);
      chk("t3_height", 32'(meas_height), 32'd4);
      pulse_clr();

      // sof mid-frame restarts
      cnt0 = int'(frame_cnt);
      send_line(W, 1, 0, -1);
      send_line(W, 0, 0, -1);
      send_frame(W, H, -1, -1, -1);
      chk("t4_err_sof", 32'(err_sof), 32'd1);
      chk("t4_cnt", 32'(frame_cnt), 32'(cnt0 + 1));
      chk("t4_height", 32'(meas_height), 32'd4);
      pulse_clr();

      // beats before sof, then clear colliding with a new error, then 4x1 frame
      rst = 1; tick(); rst = 0; tick();
      for (int i = 0; i < 3; i++) begin
         s_axis_valid = 1; tick();
      end
      s_axis_valid = 0;
      chk("t5_err_no_sof", 32'(err_no_sof), 32'd1);
      s_axis_valid = 1; err_clr = 1; tick(); s_axis_valid = 0; err_clr = 0;
      chk("t5_set_wins", 32'(err_no_sof), 32'd1);
      done0 = n_done;
      send_line(4, 1, 1, -1);
      chk("t5_done", 32'(n_done - done0), 32'd1);
      chk("t5_width", 32'(meas_width), 32'd4);
      chk("t5_height", 32'(meas_height), 32'd1);
      pulse_clr();

      // reset mid-frame
      send_line(W, 1, 0, -1);
      send_line(W, 0, 0, -1);
      for (int i = 0; i < 3; i++) begin
         s_axis_valid = 1; s_axis_sof = 0; s_axis_eol = 0; tick();
      end
      rst = 1; tick();
      chk("t6_ready_in_rst", 32'(s_axis_ready), 32'd0);
      chk("t6_cnt_zero", 32'(frame_cnt), 32'd0);
      rst = 0; s_axis_valid = 0; tick();
      send_frame(W, H, -1, -1, -1);
      chk("t6_cnt", 32'(frame_cnt), 32'd1);
      chk("t6_flags", 32'({err_no_sof, err_sof, err_width, err_height, err_data}), 32'd0);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/image_stream_checker.md
Name: image_stream_checker

Overview:
- Sink stage directly downstream of the image pattern generator.
- Consumes the pixel stream (valid/data/sof/eol/eof) and measures frame geometry.
- Checks framing-marker consistency and the constant data pattern.
- Reports per-frame results plus sticky error flags for board bring-up and regression benches.

Parameters:
PIXEL_BITWIDTH, 8, bits per pixel
PIXEL_NUM, 1, pixels per beat
EXP_WIDTH, 300, expected pixels per line
EXP_HEIGHT, 300, expected lines per frame
EXP_DATA, 8'hAA, expected pixel value, replicated per pixel lane
DIM_BITWIDTH, 13, width of the measurement counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
err_clr  in  1  clears the sticky error flags
s_axis_ready  out  1  sink ready
s_axis_valid  in  1  beat valid
s_axis_data  in  PIXEL_BITWIDTH*PIXEL_NUM  pixel data
s_axis_sof  in  1  first beat of frame
s_axis_eof  in  1  first beat of last line
s_axis_eol  in  1  last beat of each line
frame_done  out  1  one-cycle pulse when a frame completes
meas_width  out  DIM_BITWIDTH  pixels in the last line of the completed frame
meas_height  out  DIM_BITWIDTH  lines in the completed frame
frame_cnt  out  16  completed frames, wraps at 0xFFFF -> 0
err_no_sof  out  1  sticky: beat arrived outside a frame without sof
err_sof  out  1  sticky: sof arrived inside a frame
err_width  out  1  sticky: a line length differs from EXP_WIDTH
err_height  out  1  sticky: frame height differs from EXP_HEIGHT
err_data  out  1  sticky: a pixel differs from EXP_DATA

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - s_axis_ready = 0 while rst is high, 1 from the first cycle after rst deasserts; it is never deasserted otherwise.
  - All other outputs are 0 and the FSM is in WAIT_SOF.
- Beat definition: beat = s_axis_valid & s_axis_ready. Markers are ignored on non-beat cycles.
- Protocol:
  - sof marks the first beat of line 0.
  - eof marks the first beat of the final line.
  - eol marks the last beat of every line.
- FSM states: WAIT_SOF, ACTIVE, LAST_LINE.
- WAIT_SOF:
  - Beat with sof: clear pix_cnt and line_cnt, then process the beat. Go to LAST_LINE if eof is also set, else ACTIVE.
  - Beat without sof: set err_no_sof; the beat is otherwise dropped.
- ACTIVE / LAST_LINE:
  - Every beat adds PIXEL_NUM to pix_cnt; saturate at all-ones.
  - Beat with eol:
    - line_len = pix_cnt + PIXEL_NUM.
    - If line_len != EXP_WIDTH, set err_width.
    - Clear pix_cnt and increment line_cnt (saturating).
  - ACTIVE beat with eof -> LAST_LINE.
  - LAST_LINE beat with eol ends the frame:
    - meas_width <= line_len.
    - meas_height <= line_cnt + 1.
    - Set err_height if that height != EXP_HEIGHT.
    - frame_cnt increments; frame_done pulses.
    - FSM returns to WAIT_SOF.
- Simultaneous markers on one beat:
  - sof+eol: one-beat first line; counted normally.
  - sof+eof: one-line frame.
  - eof+eol in the same beat while in ACTIVE: frame ends on that beat.
- sof inside ACTIVE/LAST_LINE:
  - Set err_sof.
  - Abandon the current frame with no frame_done and no measurement update.
  - Restart counting with this beat as the new frame's first beat.
- Data check: on every in-frame beat, compare each pixel lane to EXP_DATA; any mismatch sets err_data.
- Latency: meas_width, meas_height, frame_cnt and frame_done all update on the clock edge after the final eol beat, in the same cycle as each other.
- Sticky flags:
  - Cleared only by rst or err_clr.
  - If err_clr and a new error occur in the same cycle, the error wins (flag reads 1).
- Reset mid-frame: all state is discarded; the next frame must start with sof.
- Arithmetic: counters are DIM_BITWIDTH bits unsigned; comparisons against parameters are zero-extended.

Decomposition:
- Shared package `image_pkg`:
  - FSM state encoding (WAIT_SOF=0, ACTIVE=1, LAST_LINE=2).
  - Default image dimensions, 300x300.
  - DIM_BITWIDTH default.
- One natural sub-module, `sticky_flag`: set/clear flag register with set-priority, instantiated five times.

Test Plan:
1. Nominal 300x300 frames of 0xAA from the pattern generator, ready held 1, two frames -> two frame_done pulses; meas_width=300, meas_height=300, frame_cnt=2; all error flags 0.
2. Corrupt a single pixel to 0x55 at line 10, pixel 7 -> err_data=1 and stays 1 until err_clr; then pulse err_clr -> 0; other flags remain 0.
3. Drop one beat in line 5 (299-pixel line) -> err_width=1; frame still completes with meas_height=300.
4. Inject sof at line 120 mid-frame, then send a full 300x300 frame -> err_sof=1; frame_cnt increments once for the restarted frame, with meas_height=300.
5. Send beats before any sof after reset, then a 4x1 frame with sof+eof on beat 0 and eol on beat 3 (EXP set to 4x1) -> err_no_sof=1; frame_done pulses; meas_width=4, meas_height=1.
6. Assert rst for one cycle during line 50 -> all outputs 0 the next cycle; s_axis_ready=0 while rst is high; the next full frame is measured cleanly with frame_cnt=1.
